regfile_dw: RTL and testbench
=============================

Name: regfile_dw

Overview:
- Y86-64 program register file, shared by the pipeline's Decode and Write-back stages.
- Decode reads operands through ports A/B, addressed by d_srcA/d_srcB from the source/destination selector.
- Write-back commits valE/valM through ports E/M, addressed by W_dstE/W_dstM.
- Holds the 15 architectural registers (%rax..%r14); a debug port exposes contents to the bench.

Parameters:
- DATA_W, 64, register width in bits.
- NUM_REGS, 15, architectural register count; IDs 0..14 are valid, 4'hF (`NREG) means "no register".

Ports:
- clk_i  input  1  clock; all writes on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- d_srcA_i  input  4  read address A; `NREG is allowed.
- d_srcB_i  input  4  read address B; `NREG is allowed.
- d_rvalA_o  output  DATA_W  read data A; combinational.
- d_rvalB_o  output  DATA_W  read data B; combinational.
- W_we_i  input  1  write-back enable; 0 while the W stage is stalled or holds a bubble.
- W_dstE_i  input  4  port E write address.
- W_valE_i  input  DATA_W  port E write data.
- W_dstM_i  input  4  port M write address.
- W_valM_i  input  DATA_W  port M write data.
- dbg_addr_i  input  4  debug read address.
- dbg_data_o  output  DATA_W  debug read data; combinational.
- rsp_o  output  DATA_W  current %rsp (ID 4, `RSP); registered storage value, no bypass.

Behaviour:
- Reset: rst_i high clears all 15 registers to 0 immediately, without waiting for a clock edge.
  - While rst_i is high, d_rvalA_o, d_rvalB_o, dbg_data_o and rsp_o all read 0.
  - A write presented in a cycle where rst_i is asserted is dropped.
  - Deasserting reset between edges causes no write; writes resume on the first rising edge with rst_i low.
- Write, on rising edge with W_we_i=1:
  - reg[W_dstE_i] <= W_valE_i when W_dstE_i != `NREG.
  - reg[W_dstM_i] <= W_valM_i when W_dstM_i != `NREG.
  - Simultaneous write to the same ID (e.g. popq %rsp): port M wins, port E is discarded.
  - W_we_i=0: no register changes.
  - Write IDs 0..14 only; 4'hF is ignored.
- Read (combinational, zero latency):
  - Address `NREG returns 0.
  - Otherwise returns the stored value, subject to the optional feature below.
  - Identical addresses on A and B return identical data.
- Write latency: a value written at edge N is visible on all read ports in the cycle after edge N.
- No internal FSM beyond register storage. Register state persists indefinitely between writes.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Ports A and B forward same-cycle write-back data when W_we_i=1 and the read address matches W_dstM_i or W_dstE_i (not `NREG).
  - M takes priority over E; this mirrors the write priority.
  - dbg_data_o and rsp_o are never bypassed.
- Undefined:
  - Reads return pre-edge storage only.
  - Decode forwarding logic resolves the same-cycle W hazard.

Decomposition:
- Shared package/define.v already holds `RSP (4'h4) and `NREG (4'hF); reuse them.
- Add REG_COUNT (15) and a DATA_W default constant there.
- One natural sub-module: regfile_rdport.
  - Pure mux: address -> data, with `NREG zeroing and the optional bypass.
  - Instantiated three times: A, B, debug (debug instance with bypass tied off).

Test Plan:
- Reset: preload via writes, assert rst_i mid-cycle (no edge) -> dbg_data_o for IDs 0..14 reads 0 immediately; rsp_o=0.
- Dual write: W_we_i=1, dstE=2/valE=0x11, dstM=3/valM=0x22 -> next cycle srcA=2 reads 0x11, srcB=3 reads 0x22.
- Conflict: dstE=dstM=4, valE=0x100, valM=0x200 -> rsp_o=0x200 after edge.
- NREG handling: dstE=dstM=4'hF with W_we_i=1 -> all registers unchanged; srcA=srcB=4'hF -> both read 0.
- Stall: W_we_i=0, dstE=5, valE=0xDEAD -> reg 5 keeps its prior value 0x0.
- Bypass (REGFILE_BYPASS_EN defined): reg 6 = 0x1, same cycle dstE=6/valE=0x7, srcA=6 -> d_rvalA_o=0x7 before the edge, while dbg_addr_i=6 gives 0x1. With the macro undefined -> d_rvalA_o=0x1.

Source files
------------

// File: rtl/regfile_dw_pkg.sv
// regfile_dw_pkg: shared register IDs and sizing constants for the Y86-64 register file.
package regfile_dw_pkg;
    localparam logic [3:0] RSP        = 4'h4;
    localparam logic [3:0] NREG       = 4'hF;
    localparam int         REG_COUNT  = 15;
    localparam int         DATA_W_DEF = 64;
endpackage

// File: rtl/regfile_dw_rdport.sv
// regfile_dw_rdport: combinational read mux with NREG zeroing and optional same-cycle forwarding.
module regfile_dw_rdport
    import regfile_dw_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [REG_COUNT-1:0][DATA_W-1:0] regs_i,
    input  logic [3:0]                       addr_i,
    input  logic                             byp_en_i,
    input  logic [3:0]                       dst_e_i,
    input  logic [DATA_W-1:0]                val_e_i,
    input  logic [3:0]                       dst_m_i,
    input  logic [DATA_W-1:0]                val_m_i,
    output logic [DATA_W-1:0]                data_o
);
    logic hit_e;
    logic hit_m;
    // NREG is tested first, so a matching NREG destination can never forward
    always_comb begin
        hit_m  = byp_en_i && (addr_i == dst_m_i);
        hit_e  = byp_en_i && (addr_i == dst_e_i);
        data_o = (addr_i == NREG) ? '0 :
                 hit_m            ? val_m_i :
                 hit_e            ? val_e_i : regs_i[addr_i];
    end
endmodule

// File: rtl/regfile_dw.sv
// regfile_dw: 15-entry Y86-64 register file, two read ports, two write ports (M beats E).
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data onto ports A and B.
module regfile_dw
    import regfile_dw_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        d_srcA_i,
    input  logic [3:0]        d_srcB_i,
    output logic [DATA_W-1:0] d_rvalA_o,
    output logic [DATA_W-1:0] d_rvalB_o,
    input  logic              W_we_i,
    input  logic [3:0]        W_dstE_i,
    input  logic [DATA_W-1:0] W_valE_i,
    input  logic [3:0]        W_dstM_i,
    input  logic [DATA_W-1:0] W_valM_i,
    input  logic [3:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic [DATA_W-1:0] rsp_o
);
    logic [REG_COUNT-1:0][DATA_W-1:0] regs_q;
    logic [REG_COUNT-1:0][DATA_W-1:0] regs_d;
    logic                             byp_en;

`ifdef REGFILE_BYPASS_EN
    // reads must stay zero while reset is held, even if a write is presented
    assign byp_en = W_we_i && !rst_i;
`else
    assign byp_en = 1'b0;
`endif

    // M is applied after E so it wins on a shared destination (popq %rsp)
    always_comb begin
        regs_d = regs_q;
        if (W_we_i && W_dstE_i != NREG) regs_d[W_dstE_i] = W_valE_i;
        if (W_we_i && W_dstM_i != NREG) regs_d[W_dstM_i] = W_valM_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) regs_q <= '0;
        else       regs_q <= regs_d;
    end

    regfile_dw_rdport #(.DATA_W(DATA_W)) u_rd_a (
        .regs_i(regs_q), .addr_i(d_srcA_i), .byp_en_i(byp_en),
        .dst_e_i(W_dstE_i), .val_e_i(W_valE_i), .dst_m_i(W_dstM_i), .val_m_i(W_valM_i),
        .data_o(d_rvalA_o)
    );

    regfile_dw_rdport #(.DATA_W(DATA_W)) u_rd_b (
        .regs_i(regs_q), .addr_i(d_srcB_i), .byp_en_i(byp_en),
        .dst_e_i(W_dstE_i), .val_e_i(W_valE_i), .dst_m_i(W_dstM_i), .val_m_i(W_valM_i),
        .data_o(d_rvalB_o)
    );

    regfile_dw_rdport #(.DATA_W(DATA_W)) u_rd_dbg (
        .regs_i(regs_q), .addr_i(dbg_addr_i), .byp_en_i(1'b0),
        .dst_e_i(W_dstE_i), .val_e_i(W_valE_i), .dst_m_i(W_dstM_i), .val_m_i(W_valM_i),
        .data_o(dbg_data_o)
    );

    assign rsp_o = regs_q[RSP];
endmodule

// File: tb/tb_regfile_dw.sv
// tb_regfile_dw: randomized scoreboard bench for regfile_dw against an array-based register model.
module tb_regfile_dw;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  d_srcA_i = 4'hF;
    logic [3:0]  d_srcB_i = 4'hF;
    logic [63:0] d_rvalA_o;
    logic [63:0] d_rvalB_o;
    logic        W_we_i = 1'b0;
    logic [3:0]  W_dstE_i = 4'hF;
    logic [63:0] W_valE_i = '0;
    logic [3:0]  W_dstM_i = 4'hF;
    logic [63:0] W_valM_i = '0;
    logic [3:0]  dbg_addr_i = 4'h0;
    logic [63:0] dbg_data_o;
    logic [63:0] rsp_o;

    regfile_dw dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .d_rvalA_o(d_rvalA_o), .d_rvalB_o(d_rvalB_o),
        .W_we_i(W_we_i), .W_dstE_i(W_dstE_i), .W_valE_i(W_valE_i),
        .W_dstM_i(W_dstM_i), .W_valM_i(W_valM_i),
        .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o), .rsp_o(rsp_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem[15];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [63:0] ref_rd(input logic [3:0] a, input bit byp,
                                           input logic [3:0] de, input logic [63:0] ve,
                                           input logic [3:0] dm, input logic [63:0] vm);
        if (a == 4'hF) return 64'h0;
        if (byp && a == dm) return vm;
        if (byp && a == de) return ve;
        return mem[a];
    endfunction

    function automatic void push(input string n, input int s, input logic [63:0] e);
        exp_t x;
        x.name = n;
        x.sel  = s;
        x.exp  = e;
        sb.push_back(x);
    endfunction

    task automatic drive(input bit rst, input bit we,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm,
                         input logic [3:0] sa, input logic [3:0] sbb, input logic [3:0] dbg);
        bit byp;
        @(posedge clk_i);
        #1;
        rst_i = rst; W_we_i = we;
        W_dstE_i = de; W_valE_i = ve; W_dstM_i = dm; W_valM_i = vm;
        d_srcA_i = sa; d_srcB_i = sbb; dbg_addr_i = dbg;
        if (rst) foreach (mem[i]) mem[i] = 64'h0;
`ifdef REGFILE_BYPASS_EN
        byp = !rst && we;
`else
        byp = 1'b0;
`endif
        push("rvalA", 0, ref_rd(sa, byp, de, ve, dm, vm));
        push("rvalB", 1, ref_rd(sbb, byp, de, ve, dm, vm));
        push("dbg",   2, ref_rd(dbg, 1'b0, de, ve, dm, vm));
        push("rsp",   3, mem[4]);
        // architectural effect of this cycle's write-back, seen from the next cycle on
        if (!rst && we) begin
            if (de != 4'hF) mem[de] = ve;
            if (dm != 4'hF) mem[dm] = vm;
        end
    endtask

    always @(negedge clk_i) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [63:0] got;
            e   = sb.pop_front();
            got = (e.sel == 0) ? d_rvalA_o : (e.sel == 1) ? d_rvalB_o :
                  (e.sel == 2) ? dbg_data_o : rsp_o;
            vectors++;
            if (got !== e.exp) begin
                miscompares++;
                $display("FAIL %s at %0t: got %h expected %h", e.name, $time, got, e.exp);
            end
        end
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [3:0] rnd_id();
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        foreach (mem[i]) mem[i] = 64'h0;
        // reset state
        drive(1, 0, 4'hF, 0, 4'hF, 0, 4'h0, 4'h4, 4'h4);
        // preload every register, then assert reset mid-cycle
        for (int i = 0; i < 15; i++)
            drive(0, 1, 4'(i), rnd64(), 4'hF, rnd64(), 4'(i), 4'hF, 4'(i));
        for (int i = 0; i < 15; i++)
            drive(1, 1, 4'(i), rnd64(), 4'((i + 3) % 15), rnd64(), 4'(i), 4'((i + 7) % 15), 4'(i));
        drive(0, 0, 4'h2, 0, 4'h3, 0, 4'h2, 4'h3, 4'h4);
        // dual write then read back
        drive(0, 1, 4'h2, 64'h11, 4'h3, 64'h22, 4'hF, 4'hF, 4'h0);
        drive(0, 0, 4'hF, 0, 4'hF, 0, 4'h2, 4'h3, 4'h2);
        // same-destination conflict: port M wins
        drive(0, 1, 4'h4, 64'h100, 4'h4, 64'h200, 4'h4, 4'h4, 4'h4);
        drive(0, 0, 4'hF, 0, 4'hF, 0, 4'h4, 4'h4, 4'h4);
        // NREG destinations and NREG reads
        drive(0, 1, 4'hF, rnd64(), 4'hF, rnd64(), 4'hF, 4'hF, 4'hF);
        drive(0, 0, 4'hF, 0, 4'hF, 0, 4'h2, 4'h3, 4'h4);
        // stalled write-back
        drive(0, 0, 4'h5, 64'hDEAD, 4'hF, 0, 4'h5, 4'h5, 4'h5);
        drive(0, 0, 4'hF, 0, 4'hF, 0, 4'h5, 4'h5, 4'h5);
        // same-cycle read of a register being written
        drive(0, 1, 4'h6, 64'h1, 4'hF, 0, 4'h0, 4'h0, 4'h0);
        drive(0, 1, 4'h6, 64'h7, 4'hF, 0, 4'h6, 4'h6, 4'h6);
        drive(0, 1, 4'h7, 64'h8, 4'h6, 64'h9, 4'h6, 4'h7, 4'h6);
        drive(0, 0, 4'hF, 0, 4'hF, 0, 4'h6, 4'h7, 4'h7);
        // randomized traffic with occasional reset pulses
        for (int n = 0; n < 600; n++) begin
            logic [3:0] de;
            de = rnd_id();
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                  de, rnd64(), ($urandom_range(0, 7) == 0) ? de : rnd_id(), rnd64(),
                  rnd_id(), rnd_id(), rnd_id());
        end
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
